// File: rtl/frame_stream_transmitter.sv
// frame_stream_transmitter: reads a frame from AXI memory in line-ordered bursts and replays it as an AXI4-Stream video stream.
// Define FRAME_TX_LINE_PAD_EN to add a line_stride input for padded line pitches.
module frame_stream_transmitter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_ready,
  input  logic [ADDR_WIDTH-1:0] base_addr_in,
  input  logic [15:0]           frame_width,
  input  logic [15:0]           frame_height,
`ifdef FRAME_TX_LINE_PAD_EN
  input  logic [15:0]           line_stride,
`endif
  output logic                  start_read,
  output logic [ADDR_WIDTH-1:0] read_addr,
  output logic [31:0]           read_len,
  output logic [2:0]            read_size,
  output logic [1:0]            read_burst,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  rvalid,
  input  logic                  rlast,
  output logic                  rready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  busy
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int BSH = $clog2(DATA_WIDTH / 8);

  typedef enum logic [2:0] {IDLE, REQ, WAIT_AR, DATA, DONE} state_t;
  state_t r_state, w_next;

  logic [ADDR_WIDTH-1:0] r_base, r_pend_base;
  logic [15:0] r_width, r_height, r_stride, r_line, r_col, r_beats, r_x, r_y;
  logic [15:0] r_pend_width, r_pend_height, r_pend_stride;
  logic r_pend;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic r_tvalid, r_tlast, r_tuser;

  logic [15:0] w_stride_in, w_rem, w_beats, w_col_nx;
  logic [31:0] w_offset;
  logic w_fr_ok, w_take_pend, w_take_new, w_credit, w_full, w_wr, w_rd;
  logic w_burst_end, w_eol, w_last_line, w_drained;

`ifdef FRAME_TX_LINE_PAD_EN
  assign w_stride_in = (line_stride < frame_width) ? frame_width : line_stride;
`else
  assign w_stride_in = frame_width;
`endif

  assign w_fr_ok     = frame_ready && (frame_width != '0) && (frame_height != '0);
  assign w_take_pend = (r_state == IDLE) && r_pend;
  assign w_take_new  = (r_state == IDLE) && !r_pend && w_fr_ok;
  assign w_rem       = r_width - r_col;
  assign w_beats     = (w_rem > 16'(MAX_BURST)) ? 16'(MAX_BURST) : w_rem;
  // Only one burst is ever outstanding, so at REQ nothing is in flight and free slots are depth minus count.
  assign w_credit    = (32'(FIFO_DEPTH) - 32'(r_count)) >= 32'(w_beats);
  assign w_offset    = 32'(r_line) * 32'(r_stride) + 32'(r_col);
  assign start_read  = (r_state == REQ) && w_credit;
  assign read_addr   = (r_state == REQ) ? r_base + ADDR_WIDTH'(w_offset << BSH) : '0;
  assign read_len    = (r_state == REQ) ? 32'(w_beats) - 32'd1 : '0;
  assign read_size   = 3'(BSH);
  assign read_burst  = 2'b01;
  assign w_full      = r_count == CW'(FIFO_DEPTH);
  assign rready      = (r_state == DATA) && !w_full;
  assign w_wr        = rvalid && rready;
  assign w_rd        = (r_count != '0) && (!r_tvalid || m_axis_tready);
  assign w_burst_end = w_wr && rlast;
  assign w_col_nx    = r_col + r_beats;
  assign w_eol       = w_col_nx == r_width;
  assign w_last_line = w_eol && (r_line == r_height - 16'd1);
  assign w_drained   = (r_count == '0) && (!r_tvalid || m_axis_tready);
  assign busy        = r_state != IDLE;

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tuser  = r_tuser;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (r_pend || w_fr_ok) ? REQ : IDLE;
      REQ:     w_next = w_credit ? WAIT_AR : REQ;
      WAIT_AR: w_next = arready ? DATA : WAIT_AR;
      DATA:    w_next = w_burst_end ? (w_last_line ? DONE : REQ) : DATA;
      DONE:    w_next = w_drained ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend        <= 1'b0;
      r_pend_base   <= '0;
      r_pend_width  <= '0;
      r_pend_height <= '0;
      r_pend_stride <= '0;
      r_base        <= '0;
      r_width       <= '0;
      r_height      <= '0;
      r_stride      <= '0;
      r_line        <= '0;
      r_col         <= '0;
      r_beats       <= '0;
    end else begin
      if (w_fr_ok && (r_state != IDLE || r_pend)) begin
        r_pend        <= 1'b1;
        r_pend_base   <= base_addr_in;
        r_pend_width  <= frame_width;
        r_pend_height <= frame_height;
        r_pend_stride <= w_stride_in;
      end else if (w_take_pend) begin
        r_pend <= 1'b0;
      end
      if (w_take_pend || w_take_new) begin
        r_base   <= w_take_pend ? r_pend_base : base_addr_in;
        r_width  <= w_take_pend ? r_pend_width : frame_width;
        r_height <= w_take_pend ? r_pend_height : frame_height;
        r_stride <= w_take_pend ? r_pend_stride : w_stride_in;
        r_line   <= '0;
        r_col    <= '0;
      end
      if (start_read) r_beats <= w_beats;
      if (w_burst_end) begin
        r_col <= w_eol ? '0 : w_col_nx;
        if (w_eol) r_line <= r_line + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= rdata;
  end

  // Position counters label each pixel as it enters the output register, so tuser/tlast travel with tdata.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tlast  <= 1'b0;
      r_tuser  <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_wr) - CW'(w_rd);
      if (w_rd) begin
        r_tvalid <= 1'b1;
        r_tdata  <= r_mem[r_rptr];
        r_tuser  <= (r_x == '0) && (r_y == '0);
        r_tlast  <= r_x == r_width - 16'd1;
        r_x      <= (r_x == r_width - 16'd1) ? '0 : r_x + 16'd1;
        if (r_x == r_width - 16'd1) r_y <= (r_y == r_height - 16'd1) ? '0 : r_y + 16'd1;
      end else if (m_axis_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_frame_stream_transmitter.sv
// tb_frame_stream_transmitter: randomized bench for frame_stream_transmitter with a memory/read-master model
// and a frame-level reference of the expected requests and pixels.
module tb_frame_stream_transmitter;
  localparam int DW = 32;
  localparam int AWD = 32;
  localparam int MB = 16;
  localparam int FD = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_ready = 1'b0;
  logic [AWD-1:0] base_addr_in;
  logic [15:0] frame_width, frame_height;
`ifdef FRAME_TX_LINE_PAD_EN
  logic [15:0] line_stride = '0;
`endif
  logic start_read, rready, arready, rvalid, rlast, busy;
  logic [AWD-1:0] read_addr;
  logic [31:0] read_len;
  logic [2:0] read_size;
  logic [1:0] read_burst;
  logic [DW-1:0] rdata, m_axis_tdata;
  logic m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;

  always #5 clk = ~clk;

  frame_stream_transmitter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWD), .MAX_BURST(MB), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .frame_ready(frame_ready), .base_addr_in(base_addr_in),
    .frame_width(frame_width), .frame_height(frame_height),
`ifdef FRAME_TX_LINE_PAD_EN
    .line_stride(line_stride),
`endif
    .start_read(start_read), .read_addr(read_addr), .read_len(read_len), .read_size(read_size),
    .read_burst(read_burst), .arready(arready), .rdata(rdata), .rvalid(rvalid), .rlast(rlast),
    .rready(rready), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .busy(busy)
  );

  typedef struct {logic [31:0] d; logic u; logic l; logic eof;} px_t;
  typedef struct {logic [31:0] a; logic [31:0] len;} rq_t;
  px_t exp_px[$];
  rq_t exp_rq[$];

  int n_cmp = 0, n_err = 0, n_acc = 0, n_out = 0;
  int mode = 0, hold = 0, m_phase = 0, m_dly = 0, m_stray = 0, m_i = 0;
  logic [31:0] m_addr, m_len;
  logic m_abort = 1'b0, c_flush = 1'b0, prev_stall = 1'b0, busy_due = 1'b0;
  logic [33:0] prev_word;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC3A5_0F1E;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: one request per MB-sized chunk of each line, pixels in raster order.
  task automatic model_frame(input logic [31:0] b, input int w, input int h);
    for (int y = 0; y < h; y++) begin
      for (int c = 0; c < w; c += MB)
        exp_rq.push_back('{b + 32'((y * w + c) * 4), 32'((((w - c) < MB) ? (w - c) : MB) - 1)});
      for (int x = 0; x < w; x++)
        exp_px.push_back('{memw(b + 32'((y * w + x) * 4)), (x == 0 && y == 0), (x == w - 1), (x == w - 1 && y == h - 1)});
    end
  endtask

  task automatic send_frame(input logic [31:0] b, input int w, input int h);
    @(negedge clk);
    base_addr_in = b;
    frame_width = 16'(w);
    frame_height = 16'(h);
    frame_ready = 1'b1;
    if (w > 0 && h > 0) model_frame(b, w, h);
    @(negedge clk);
    frame_ready = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    do begin @(negedge clk); n++; end while ((exp_px.size() != 0 || busy) && n < lim);
    #3;
    chk("drain_px", 64'(exp_px.size()), 64'(0));
    chk("drain_rq", 64'(exp_rq.size()), 64'(0));
    chk("drain_busy", 64'(busy), 64'(0));
  endtask

  task automatic wait_out(input int k);
    int n = 0;
    while (n_out < k && n < 2000) begin @(negedge clk); n++; end
    chk("wait_out", 64'(n_out >= k), 64'(1));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_start"}, 64'(start_read), 64'(0));
    chk({tag, "_addr"}, 64'(read_addr), 64'(0));
    chk({tag, "_len"}, 64'(read_len), 64'(0));
    chk({tag, "_rready"}, 64'(rready), 64'(0));
    chk({tag, "_axis"}, 64'({m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_size"}, 64'(read_size), 64'(2));
    chk({tag, "_burst"}, 64'(read_burst), 64'(1));
  endtask

  // Stream sink and checker.
  initial begin
    px_t e;
    m_axis_tready = 1'b1;
    forever begin
      @(negedge clk); #1;
      if (c_flush) begin prev_stall = 1'b0; busy_due = 1'b0; c_flush = 1'b0; end
      if (busy_due) begin chk("busy_low", 64'(busy), 64'(0)); busy_due = 1'b0; end
      m_axis_tready = (hold > 0) ? 1'b0 : (mode == 0) ? 1'b1 : (mode == 1) ? ~m_axis_tready : 1'($urandom_range(0, 1));
      if (hold > 0) hold--;
      if (prev_stall)
        chk("stall_hold", 64'({m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}), 64'({1'b1, prev_word}));
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_px.size() == 0) chk("unexpected_px", 64'(m_axis_tvalid), 64'(0));
        else begin
          e = exp_px.pop_front();
          chk("px", 64'({m_axis_tuser, m_axis_tlast, m_axis_tdata}), 64'({e.u, e.l, e.d}));
          n_out++;
          busy_due = e.eof;
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_word = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    end
  end

  // Read master and memory model.
  initial begin
    rq_t r;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0;
    forever begin
      @(negedge clk); #2;
      arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
      if (m_abort) begin m_phase = 0; m_abort = 1'b0; end
      if (m_stray > 0) begin
        rvalid = 1'b1; rdata = $urandom; rlast = (m_stray == 1); m_stray--;
      end else if (m_phase == 1) begin
        if (m_dly == 0) begin arready = 1'b1; m_phase = 2; end else m_dly--;
      end else if (m_phase == 2 && $urandom_range(0, 3) != 0) begin
        rvalid = 1'b1;
        rdata = memw(m_addr + 32'(m_i * 4));
        rlast = (32'(m_i) == m_len);
        if (rready) begin
          n_acc++; m_i++;
          if (32'(m_i) > m_len) m_phase = 0;
        end
      end
      if (start_read) begin
        if (exp_rq.size() == 0) chk("unexpected_req", 64'(start_read), 64'(0));
        else begin
          r = exp_rq.pop_front();
          chk("req_addr", 64'(read_addr), 64'(r.a));
          chk("req_len", 64'(read_len), 64'(r.len));
        end
        chk("credit", 64'((n_acc - n_out - int'(m_axis_tvalid && !m_axis_tready) + int'(read_len) + 1) <= FD), 64'(1));
        m_phase = 1; m_dly = $urandom_range(0, 2); m_addr = read_addr; m_len = read_len; m_i = 0;
      end
    end
  end

  initial begin
    int n, k;
    base_addr_in = '0; frame_width = '0; frame_height = '0;
    repeat (3) @(negedge clk);
    #3 chk_idle("reset");
    rst_n = 1'b1;

    send_frame(32'h100, 8, 4);
    #3;
    chk("req_latency", 64'(start_read), 64'(1));
    chk("busy_rise", 64'(busy), 64'(1));
    wait_done(2000);

    send_frame(32'h1000, 20, 2);
    wait_done(2000);

    mode = 1;
    k = n_out;
    send_frame(32'h2000, 20, 4);
    wait_out(k + 10);
    hold = 40;
    wait_done(4000);
    mode = 0;

    k = n_out;
    send_frame(32'h200, 20, 2);
    wait_out(k + 5);
    send_frame(32'h400, 8, 4);
    wait_done(4000);

    send_frame(32'h3000, 16, 4);
    n = 0;
    while (!(m_phase == 2 && n_acc >= 3) && n < 500) begin @(negedge clk); n++; end
    chk("reach_burst", 64'(m_phase == 2), 64'(1));
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    exp_px.delete(); exp_rq.delete();
    n_acc = 0; n_out = 0; m_abort = 1'b1; m_stray = 3; c_flush = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #3 chk_idle("midreset");
    n = 0;
    repeat (8) begin @(negedge clk); #3; n += int'(m_axis_tvalid) + int'(start_read) + int'(busy); end
    chk("post_reset_quiet", 64'(n), 64'(0));
    send_frame(32'h3000, 8, 2);
    wait_done(2000);

    send_frame(32'h800, 0, 4);
    send_frame(32'h800, 4, 0);
    n = 0;
    repeat (10) begin @(negedge clk); #3; n += int'(start_read) + int'(busy); end
    chk("degenerate", 64'(n), 64'(0));

    mode = 2;
    for (int i = 0; i < 6; i++) begin
      send_frame(32'($urandom_range(0, 4095)) * 32'd16, $urandom_range(1, 40), $urandom_range(1, 3));
      wait_done(4000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
